tour_cmd_sched: RTL and testbench
=================================

# tour_cmd_sched

Sequencer and command arbiter between the UART command path, the tour solver and `cmd_proc`. When idle it passes host commands straight through. On `start_tour` it takes ownership of the `cmd_proc` command interface and replays the 24 solved knight moves. Each knight move is issued as two `cmd_proc` moves, vertical then horizontal. It also generates the 8-bit host response for every completed move.

## Interface
- `NUM_MOVES`, 24: knight moves per tour; `mv_indx` runs 0..`NUM_MOVES`-1.
- `clk` in 1: system clock.
- `RST` in 1: asynchronous, active-high reset.
- `start_tour` in 1: one-cycle pulse from the solver; solution memory is valid.
- `move` in 8: one-hot knight move read from solver memory at `mv_indx`; must be stable within the cycle.
- `mv_indx` out 5: registered read index into the solver memory.
- `cmd_UART` in 16: host command from the UART wrapper.
- `cmd_rdy_UART` in 1: host command valid.
- `clr_cmd_rdy_UART` out 1: clears the UART command-ready flag.
- `cmd` out 16: command to `cmd_proc`.
- `cmd_rdy` out 1: command to `cmd_proc` is valid.
- `clr_cmd_rdy` in 1: `cmd_proc` has consumed `cmd`.
- `send_resp` in 1: `cmd_proc` has finished a move.
- `resp` out 8: response byte, sampled by the UART wrapper on `send_resp`.

## Operation
- Command format: `[15:12]` opcode, `[11:4]` heading, `[3:0]` squares.
  - Opcode MOVE is 4'h4; MOVE_FANFARE is 4'h5.
  - Headings: N 8'h00, W 8'h3F, S 8'h7F, E 8'hBF.
- Move decode (N = +y, E = +x). Vertical leg comes first, horizontal second:
  - bit0: N2 W1
  - bit1: N2 E1
  - bit2: N1 W2
  - bit3: S1 W2
  - bit4: S2 W1
  - bit5: S2 E1
  - bit6: S1 E2
  - bit7: N1 E2
  - If several bits are set, the lowest set bit wins.
  - `move` == 0 decodes to a 0-square N command for both legs.
- Vertical leg is always opcode MOVE. Horizontal leg opcode depends on `TOUR_FANFARE_EN`.
- States: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
  - IDLE: on `start_tour` load `mv_indx`=0 and go to VERT.
  - VERT: `cmd` = vertical leg, `cmd_rdy`=1. On `clr_cmd_rdy` go to WAIT_V.
  - WAIT_V: `cmd_rdy`=0. On `send_resp` go to HORZ.
  - HORZ: `cmd` = horizontal leg, `cmd_rdy`=1. On `clr_cmd_rdy` go to WAIT_H.
  - WAIT_H: on `send_resp`, if `mv_indx`==`NUM_MOVES`-1 go to IDLE, else increment `mv_indx` and go to VERT.
- Pass-through (IDLE only):
  - `cmd`=`cmd_UART`, `cmd_rdy`=`cmd_rdy_UART`, `clr_cmd_rdy_UART`=`clr_cmd_rdy`.
  - `clr_cmd_rdy_UART`=0 in every other state.
- `resp`:
  - 8'h5A in IDLE.
  - 8'h5A in WAIT_H when `mv_indx`==`NUM_MOVES`-1.
  - 8'hA5 otherwise.
- Boundary conditions:
  - `start_tour` together with `cmd_rdy_UART` in IDLE: tour wins. The UART command stays pending (not cleared) and is passed through once the FSM returns to IDLE.
  - `start_tour` outside IDLE: ignored.
  - `clr_cmd_rdy` in a WAIT state, or `send_resp` in VERT/HORZ: ignored, no transition.
  - `RST` mid-tour: immediate return to IDLE with `mv_indx`=0. Any in-flight `cmd_proc` move is not tracked.

## Timing
- Reset values:
  - state IDLE, `mv_indx` 0.
  - Combinational outputs follow IDLE: `cmd`=`cmd_UART`, `cmd_rdy`=`cmd_rdy_UART`, `clr_cmd_rdy_UART`=`clr_cmd_rdy`, `resp` 8'h5A.
- State and `mv_indx` are registered. `cmd`, `cmd_rdy`, `clr_cmd_rdy_UART` and `resp` are combinational from state, `mv_indx`, `move` and the UART inputs.
- `start_tour` at edge N puts `cmd_rdy`=1 with move 0's vertical leg from N+1.
- `cmd_rdy` drops in the cycle after `clr_cmd_rdy` is sampled.
- `send_resp` in WAIT_H at edge N updates `mv_indx` at N+1. Solver memory must present the new `move` combinationally in that cycle.
- Every state is exited only on an input event; there are no internal timeouts.

## Configuration
- `TOUR_FANFARE_EN` defined: horizontal leg uses opcode MOVE_FANFARE (4'h5), so the buzzer plays at each square reached.
- Not defined: horizontal leg uses MOVE (4'h4); commands differ only in the opcode field.

## Structure
- Package `tour_pkg` holds:
  - opcode constants, heading constants, POS_ACK 8'hA5, ACK 8'h5A;
  - the state enum;
  - a `leg_t` struct {heading[7:0], squares[3:0]}.
- Sub-module `tour_move_decode`: combinational, `move[7:0]` in, vertical and horizontal `leg_t` out. Lowest-set-bit priority lives here.

## Test plan
- Pass-through: IDLE, `cmd_UART`=16'h2000, `cmd_rdy_UART`=1, pulse `clr_cmd_rdy` -> `cmd`=16'h2000, `clr_cmd_rdy_UART` pulses, `resp`=8'h5A.
- Single move: `start_tour`, `move`=8'h02 -> `cmd`=16'h4002, then after `clr_cmd_rdy`/`send_resp`:
  - `cmd`=16'h5BF1 with `TOUR_FANFARE_EN`;
  - `cmd`=16'h4BF1 without;
  - `resp` 8'hA5 on both `send_resp`.
- Full tour: 24 moves of 8'h40 -> each move issues 16'h47F1 then 16'h5BF2. `mv_indx` steps 0..23. Final `send_resp` sees `resp`=8'h5A and the FSM returns to IDLE.
- Contention: `start_tour` and `cmd_rdy_UART` in the same cycle -> tour command issued, `clr_cmd_rdy_UART` stays 0 until the tour ends, then the UART command passes through.
- Reset mid-tour: assert `RST` in WAIT_V at `mv_indx`=7 -> IDLE, `mv_indx`=0, outputs in pass-through.
- Illegal move: `move`=8'h0C decodes as bit2 -> `cmd`=16'h4001, then 16'h53F2 (fanfare build).

Source files
------------

// File: rtl/tour_pkg.sv
// Shared constants, FSM state encoding and leg type for the tour command scheduler.
package tour_pkg;

  localparam logic [3:0] OP_MOVE         = 4'h4;
  localparam logic [3:0] OP_MOVE_FANFARE = 4'h5;

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;

  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] ACK     = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H
  } state_t;

  typedef struct packed {
    logic [7:0] heading;
    logic [3:0] squares;
  } leg_t;

endpackage

// File: rtl/tour_move_decode.sv
// Combinational knight-move decoder: one-hot move in, vertical and horizontal legs out.
// When several bits are set the lowest one is used; move == 0 gives two 0-square N legs.
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0] move,
  output leg_t       vert,
  output leg_t       horz
);

  logic [7:0] sel;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_low
      if (gi == 0) begin : g_first
        assign sel[gi] = move[gi];
      end else begin : g_rest
        assign sel[gi] = move[gi] & ~(|move[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    vert = '{heading: HEAD_N, squares: 4'd0};
    horz = '{heading: HEAD_N, squares: 4'd0};
    case (sel)
      8'h01: begin vert = '{HEAD_N, 4'd2}; horz = '{HEAD_W, 4'd1}; end
      8'h02: begin vert = '{HEAD_N, 4'd2}; horz = '{HEAD_E, 4'd1}; end
      8'h04: begin vert = '{HEAD_N, 4'd1}; horz = '{HEAD_W, 4'd2}; end
      8'h08: begin vert = '{HEAD_S, 4'd1}; horz = '{HEAD_W, 4'd2}; end
      8'h10: begin vert = '{HEAD_S, 4'd2}; horz = '{HEAD_W, 4'd1}; end
      8'h20: begin vert = '{HEAD_S, 4'd2}; horz = '{HEAD_E, 4'd1}; end
      8'h40: begin vert = '{HEAD_S, 4'd1}; horz = '{HEAD_E, 4'd2}; end
      8'h80: begin vert = '{HEAD_N, 4'd1}; horz = '{HEAD_E, 4'd2}; end
      default: ;
    endcase
  end

endmodule

// File: rtl/tour_cmd_sched.sv
// Arbitrates cmd_proc between host pass-through and replay of a solved knight's tour.
// Define TOUR_FANFARE_EN to issue every horizontal leg with the fanfare opcode.
module tour_cmd_sched
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] HORZ_OP = OP_MOVE_FANFARE;
`else
  localparam logic [3:0] HORZ_OP = OP_MOVE;
`endif

  localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

  state_t     state_reg, state_next;
  logic [4:0] mv_indx_reg, mv_indx_next;
  leg_t       vert_leg, horz_leg;
  logic       last_move;

  tour_move_decode u_decode (
    .move (move),
    .vert (vert_leg),
    .horz (horz_leg)
  );

  assign mv_indx   = mv_indx_reg;
  assign last_move = (mv_indx_reg == LAST_INDX);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_reg   <= IDLE;
      mv_indx_reg <= 5'd0;
    end else begin
      state_reg   <= state_next;
      mv_indx_reg <= mv_indx_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    mv_indx_next     = mv_indx_reg;
    cmd              = {OP_MOVE, vert_leg};
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = POS_ACK;
    case (state_reg)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = ACK;
        // A pending host command is left untouched and resumes after the tour.
        if (start_tour) begin
          mv_indx_next = 5'd0;
          state_next   = VERT;
        end
      end
      VERT: begin
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_next = WAIT_V;
      end
      WAIT_V: begin
        if (send_resp) state_next = HORZ;
      end
      HORZ: begin
        cmd     = {HORZ_OP, horz_leg};
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_next = WAIT_H;
      end
      WAIT_H: begin
        cmd = {HORZ_OP, horz_leg};
        if (last_move) resp = ACK;
        if (send_resp) begin
          if (last_move) begin
            state_next = IDLE;
          end else begin
            mv_indx_next = mv_indx_reg + 5'd1;
            state_next   = VERT;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_sched.sv
// Directed self-checking bench for tour_cmd_sched; honours TOUR_FANFARE_EN for expected opcodes.
module tb_tour_cmd_sched;

`ifdef TOUR_FANFARE_EN
  localparam logic [3:0] HOP = 4'h5;
`else
  localparam logic [3:0] HOP = 4'h4;
`endif

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        start_tour = 1'b0;
  logic [7:0]  mv_in = 8'h00;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h2000;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp;

  int checks = 0;
  int errors = 0;

  tour_cmd_sched dut (
    .clk              (clk),
    .RST              (RST),
    .start_tour       (start_tour),
    .move             (mv_in),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller guarantees the DUT is in VERT for move index idx.
  task automatic do_move(input logic [7:0] mv, input logic [15:0] ev, input logic [15:0] eh,
                         input logic [4:0] idx, input bit last);
    mv_in = mv;
    #1;
    check("vert_cmd", 32'(cmd), 32'(ev));
    check("vert_rdy", 32'(cmd_rdy), 32'd1);
    check("vert_indx", 32'(mv_indx), 32'(idx));
    check("vert_clr_uart", 32'(clr_cmd_rdy_UART), 32'd0);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0; #1;
    check("waitv_rdy", 32'(cmd_rdy), 32'd0);
    check("waitv_resp", 32'(resp), 32'hA5);
    send_resp = 1'b1; tick(); send_resp = 1'b0; #1;
    check("horz_cmd", 32'(cmd), 32'(eh));
    check("horz_rdy", 32'(cmd_rdy), 32'd1);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0; #1;
    check("waith_rdy", 32'(cmd_rdy), 32'd0);
    check("waith_resp", 32'(resp), last ? 32'h5A : 32'hA5);
    check("waith_clr_uart", 32'(clr_cmd_rdy_UART), 32'd0);
    $display("move %0d mv=%h vert=%h horz=%h resp=%h", idx, mv, ev, eh, resp);
    send_resp = 1'b1; tick(); send_resp = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_indx", 32'(mv_indx), 32'd0);
    check("rst_cmd", 32'(cmd), 32'h2000);
    check("rst_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_resp", 32'(resp), 32'h5A);
    tick(); tick();
    RST = 1'b0;

    // Pass-through
    cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1; #1;
    check("pt_cmd", 32'(cmd), 32'h2000);
    check("pt_rdy", 32'(cmd_rdy), 32'd1);
    check("pt_clr_uart", 32'(clr_cmd_rdy_UART), 32'd1);
    check("pt_resp", 32'(resp), 32'h5A);
    $display("passthru cmd=%h clr_uart=%b", cmd, clr_cmd_rdy_UART);
    tick(); clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0; #1;
    check("pt_clr_uart_low", 32'(clr_cmd_rdy_UART), 32'd0);

    // Contention: tour starts while a host command is pending
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1; start_tour = 1'b1; mv_in = 8'h02;
    tick(); start_tour = 1'b0;
    // send_resp in VERT is ignored
    send_resp = 1'b1; tick(); send_resp = 1'b0; #1;
    check("vert_ignore_resp", 32'(cmd), 32'h4002);
    do_move(8'h02, 16'h4002, {HOP, 12'hBF1}, 5'd0, 1'b0);
    do_move(8'h0C, 16'h4001, {HOP, 12'h3F2}, 5'd1, 1'b0);
    do_move(8'h00, 16'h4000, {HOP, 12'h000}, 5'd2, 1'b0);
    do_move(8'h30, 16'h47F2, {HOP, 12'h3F1}, 5'd3, 1'b0);
    for (int i = 4; i < 24; i++) begin
      if (i == 5) begin
        start_tour = 1'b1; tick(); start_tour = 1'b0; #1;
        check("start_ignored_indx", 32'(mv_indx), 32'd5);
      end
      do_move(8'h40, 16'h47F1, {HOP, 12'hBF2}, 5'(i), i == 23);
    end
    #1;
    check("post_tour_cmd", 32'(cmd), 32'h1234);
    check("post_tour_rdy", 32'(cmd_rdy), 32'd1);
    check("post_tour_resp", 32'(resp), 32'h5A);
    clr_cmd_rdy = 1'b1; #1;
    check("post_tour_clr_uart", 32'(clr_cmd_rdy_UART), 32'd1);
    $display("post-tour passthru cmd=%h", cmd);
    tick(); clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;

    // Reset in WAIT_V of move 7
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    for (int i = 0; i < 7; i++) do_move(8'h40, 16'h47F1, {HOP, 12'hBF2}, 5'(i), 1'b0);
    #1;
    check("pre_rst_indx", 32'(mv_indx), 32'd7);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    cmd_UART = 16'h2000;
    RST = 1'b1; #1;
    check("midrst_indx", 32'(mv_indx), 32'd0);
    check("midrst_cmd", 32'(cmd), 32'h2000);
    check("midrst_rdy", 32'(cmd_rdy), 32'd0);
    check("midrst_resp", 32'(resp), 32'h5A);
    $display("reset mid-tour indx=%0d resp=%h", mv_indx, resp);
    tick(); RST = 1'b0; tick(); #1;
    check("after_rst_resp", 32'(resp), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
